multiplier_exhaustive_checker: RTL and testbench
================================================

// Module: multiplier_exhaustive_checker
// PURPOSE
//  Sequential verification stage that wraps one combinational multiplier candidate.
//  - Upstream role: drives every operand pair {A,B} into the candidate.
//  - Downstream role: consumes the candidate's product P and compares it with the exact product A*B.
//  - Reports an error count, the first failing pair and a pass flag to the design-space-exploration environment.
// PARAMETERS
//  WIDTH   2  operand width of the candidate (A and B); P is 2*WIDTH bits
//  SETTLE  1  extra cycles each vector is held before P is sampled (0..15)
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         asynchronous active-high reset
//  start        in   1         begin a sweep; honoured in IDLE or DONE only
//  abort        in   1         stop a running sweep and return to IDLE
//  mult_a       out  WIDTH     operand A to candidate (registered)
//  mult_b       out  WIDTH     operand B to candidate (registered)
//  mult_p       in   2*WIDTH   product returned by candidate (combinational path)
//  busy         out  1         high while in RUN
//  done         out  1         high in DONE; held until start, abort or rst
//  pass         out  1         done & (err_count==0)
//  err_count    out  2*WIDTH+1 number of mismatching vectors in the sweep
//  fail_valid   out  1         a mismatch has been captured
//  fail_a       out  WIDTH     A of the first mismatch
//  fail_b       out  WIDTH     B of the first mismatch
//  fail_p       out  2*WIDTH   P returned at the first mismatch
// BEHAVIOUR
//  Reset: all outputs are 0 and the state is IDLE, immediately and asynchronously.
//  Vector index: idx has 2*WIDTH bits; {mult_a,mult_b} = idx, so A is the MSB half.
//  Sweep order: idx runs from 0 to 2^(2*WIDTH)-1 (a=0,b=0..max; then a=1; and so on).
//  FSM states:
//   IDLE -> RUN when start=1.
//   RUN  -> DONE after the compare of the last idx.
//   RUN  -> IDLE when abort=1.
//   DONE -> RUN when start=1.
//   DONE -> IDLE when abort=1.
//  Entering RUN (from IDLE or DONE):
//   - clear idx, err_count, fail_* and the hold counter;
//   - drive idx 0 on the following cycle;
//   - busy rises on the same edge.
//  Hold and compare:
//   - Each vector is held for SETTLE+1 cycles.
//   - On the clock edge that ends the hold, compare mult_p with the exact product mult_a*mult_b.
//   - The exact product is computed at 2*WIDTH bits, unsigned.
//   - On a mismatch: err_count increments.
//   - On the first mismatch only: capture mult_a, mult_b and mult_p, and set fail_valid.
//   - On the same edge, idx advances; after the last idx the FSM moves to DONE.
//  Latency: from the start edge to the done-rise edge is 1 + 2^(2*WIDTH)*(SETTLE+1) cycles.
//  err_count range: at most 2^(2*WIDTH), so the width is sufficient and there is no wrap.
//  In DONE:
//   - mult_a and mult_b hold the last vector;
//   - results are stable;
//   - pass is valid.
//  start while busy: ignored.
//  start and abort in the same cycle: abort wins.
//  abort in RUN: go to IDLE with done=0 and pass=0; err_count and fail_* keep partial values.
//  rst during RUN: the sweep is lost and all outputs clear; a new start is required.
//  X/Z on mult_p counts as a mismatch (a case-inequality check is used in simulation only).
// TESTING
//  1. Exact candidate (P=A*B), WIDTH=2, SETTLE=1, start pulse -> done after 33 cycles, err_count=0, pass=1, fail_valid=0.
//  2. Candidate with P stuck at 0 -> err_count=9, fail_a=1, fail_b=1, fail_p=0, pass=0.
//  3. Candidate with P[0] inverted -> err_count=16, fail_a=0, fail_b=0, fail_p=1.
//  4. abort asserted 10 cycles into RUN -> state IDLE, busy=0, done=0; a following start gives a full sweep with correct results.
//  5. start again while in DONE with a different candidate -> counters clear and results reflect only the new sweep; start pulses during RUN have no effect.
//  6. rst asserted asynchronously mid-sweep (between edges) -> all outputs 0 at once and stay 0 until the next start.

Source files
------------

// File: rtl/multiplier_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// MultiplierExhaustiveChecker
//
// Purpose:
//   Sequential verification stage wrapped around one combinational multiplier
//   candidate. It walks every operand pair {A,B} into the candidate, compares
//   the returned product against the exact unsigned product, and reports the
//   number of mismatches, the first failing pair and a pass flag.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   start_i        begin a sweep (honoured in IDLE or DONE only)
//   abort_i        stop a running sweep and return to IDLE (wins over start)
//   mult_a_o       operand A to the candidate (registered, MSB half of idx)
//   mult_b_o       operand B to the candidate (registered, LSB half of idx)
//   mult_p_i       product returned by the candidate (combinational path)
//   busy_o         high while a sweep is running
//   done_o         high once a sweep completed; held until start/abort/rst
//   pass_o         done with zero mismatches
//   err_count_o    number of mismatching vectors in the sweep
//   fail_valid_o   a mismatch has been captured
//   fail_a_o       A of the first mismatch
//   fail_b_o       B of the first mismatch
//   fail_p_o       product returned at the first mismatch
//
// Parameters:
//   WIDTH          operand width of the candidate; product is 2*WIDTH bits
//   SETTLE         extra cycles each vector is held before sampling (0..15)
// -----------------------------------------------------------------------------
module multiplier_exhaustive_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [WIDTH-1:0]     mult_a_o,
  output logic [WIDTH-1:0]     mult_b_o,
  input  logic [2*WIDTH-1:0]   mult_p_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [2*WIDTH:0]     err_count_o,
  output logic                 fail_valid_o,
  output logic [WIDTH-1:0]     fail_a_o,
  output logic [WIDTH-1:0]     fail_b_o,
  output logic [2*WIDTH-1:0]   fail_p_o
);

  localparam int             IW        = 2 * WIDTH;
  localparam logic [IW-1:0]  LAST_IDX  = '1;
  localparam logic [IW-1:0]  IDX_ONE   = IW'(1);
  localparam logic [IW:0]    ERR_ONE   = (IW + 1)'(1);
  localparam logic [3:0]     HOLD_LAST = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic [3:0]        hold_q;
  logic              primed_q;
  logic [IW:0]       err_q;
  logic              fail_valid_q;
  logic [WIDTH-1:0]  fail_a_q;
  logic [WIDTH-1:0]  fail_b_q;
  logic [IW-1:0]     fail_p_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic [IW-1:0]     exactProd;
  logic              mismatch;
  logic              startRun;
  logic              compareNow;
  logic [IW:0]       err_d;

  // The operands seen by the candidate are simply the two halves of the
  // vector index register, so they are registered by construction.
  assign opA = idx_q[IW-1:WIDTH];
  assign opB = idx_q[WIDTH-1:0];

  // Reference product and compare. The case-inequality makes an X/Z product
  // count as a mismatch in simulation; synthesis treats it as plain !=.
  always_comb begin
    exactProd  = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
    mismatch   = (mult_p_i !== exactProd);
    startRun   = ((state_q == IDLE) || (state_q == DONE)) && start_i && !abort_i;
    compareNow = (state_q == RUN) && primed_q && (hold_q == HOLD_LAST);
    err_d      = mismatch ? (err_q + ERR_ONE) : err_q;
  end

  // Single FSM block holding the sweep state and all registered outputs.
  // The first vector gets one extra priming cycle after the start edge, so a
  // full sweep takes 1 + 2^(2*WIDTH)*(SETTLE+1) cycles from start to done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      primed_q     <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_p_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else if (startRun) begin
      state_q      <= RUN;
      idx_q        <= '0;
      hold_q       <= '0;
      primed_q     <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_p_q     <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end

        RUN: begin
          if (abort_i) begin
            // Partial results stay visible; only the status flags drop.
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            primed_q <= 1'b0;
          end else if (!primed_q) begin
            primed_q <= 1'b1;
            hold_q   <= '0;
          end else if (compareNow) begin
            err_q <= err_d;
            if (mismatch && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_a_q     <= opA;
              fail_b_q     <= opB;
              fail_p_q     <= mult_p_i;
            end
            if (idx_q == LAST_IDX) begin
              // Leave the last vector on the operands while in DONE.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              idx_q  <= idx_q + IDX_ONE;
              hold_q <= '0;
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end

        DONE: begin
          if (abort_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mult_a_o     = opA;
  assign mult_b_o     = opB;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign fail_valid_o = fail_valid_q;
  assign fail_a_o     = fail_a_q;
  assign fail_b_o     = fail_b_q;
  assign fail_p_o     = fail_p_q;

endmodule

// File: tb/tb_multiplier_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// Testbench for multiplier_exhaustive_checker.
// A behavioural candidate multiplier is selected by candMode; the reference
// model walks all operand pairs with plain loops and predicts error count,
// first failing pair and the start-to-done latency.
// -----------------------------------------------------------------------------
module tb_multiplier_exhaustive_checker;

  localparam int WIDTH  = 2;
  localparam int SETTLE = 1;
  localparam int IW     = 2 * WIDTH;
  localparam int NVEC   = 1 << IW;

  logic              clock;
  logic              reset;
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  multA;
  logic [WIDTH-1:0]  multB;
  logic [IW-1:0]     multP;
  logic              busy;
  logic              done;
  logic              pass;
  logic [IW:0]       errCount;
  logic              failValid;
  logic [WIDTH-1:0]  failA;
  logic [WIDTH-1:0]  failB;
  logic [IW-1:0]     failP;

  int                checkCount;
  int                errorCount;
  int                candMode;
  logic [IW-1:0]     lut [NVEC];

  multiplier_exhaustive_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .start_i      (start),
    .abort_i      (abort),
    .mult_a_o     (multA),
    .mult_b_o     (multB),
    .mult_p_i     (multP),
    .busy_o       (busy),
    .done_o       (done),
    .pass_o       (pass),
    .err_count_o  (errCount),
    .fail_valid_o (failValid),
    .fail_a_o     (failA),
    .fail_b_o     (failB),
    .fail_p_o     (failP)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural candidates: 0 exact, 1 stuck at zero, 2 LSB inverted,
  // 3 arbitrary lookup table filled with random corruptions.
  function automatic logic [IW-1:0] candidate(input int m, input int a, input int b);
    int prod;
    prod = a * b;
    case (m)
      0:       return IW'(prod);
      1:       return '0;
      2:       return IW'(prod ^ 1);
      default: return lut[a * (1 << WIDTH) + b];
    endcase
  endfunction

  always_comb multP = candidate(candMode, int'(multA), int'(multB));

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: walk the sweep order and summarise mismatches.
  task automatic computeModel(input int m, output int expErr, output int expValid,
                              output int expA, output int expB, output int expP);
    expErr = 0; expValid = 0; expA = 0; expB = 0; expP = 0;
    for (int a = 0; a < (1 << WIDTH); a++) begin
      for (int b = 0; b < (1 << WIDTH); b++) begin
        int p;
        p = int'(candidate(m, a, b));
        if (p != ((a * b) % NVEC)) begin
          expErr++;
          if (expValid == 0) begin
            expValid = 1; expA = a; expB = b; expP = p;
          end
        end
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},  32'(busy), 0);
    checkOutput({tag, "_done"},  32'(done), 0);
    checkOutput({tag, "_pass"},  32'(pass), 0);
    checkOutput({tag, "_err"},   32'(errCount), 0);
    checkOutput({tag, "_fv"},    32'(failValid), 0);
    checkOutput({tag, "_fa"},    32'(failA), 0);
    checkOutput({tag, "_fb"},    32'(failB), 0);
    checkOutput({tag, "_fp"},    32'(failP), 0);
    checkOutput({tag, "_a"},     32'(multA), 0);
    checkOutput({tag, "_b"},     32'(multB), 0);
  endtask

  // Issue a start pulse; the edge that samples it is the start edge.
  task automatic pulseStart();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  // Run one full sweep with candidate m, optionally pulsing start mid-run,
  // and check latency and results against the model.
  task automatic applyStimulus(input string tag, input int m, input bit midStarts);
    int expErr, expValid, expA, expB, expP, cnt;
    candMode = m;
    computeModel(m, expErr, expValid, expA, expB, expP);
    pulseStart();
    checkOutput({tag, "_busyAtStart"}, 32'(busy), 1);
    checkOutput({tag, "_doneAtStart"}, 32'(done), 0);
    cnt = 0;
    while (cnt < 2000) begin
      @(posedge clock); #1;
      cnt++;
      start = 1'b0;
      if (done) break;
      if (midStarts && (cnt == 7 || cnt == 20)) start = 1'b1;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cnt), 32'(1 + NVEC * (SETTLE + 1)));
    checkOutput({tag, "_err"},     32'(errCount), 32'(expErr));
    checkOutput({tag, "_pass"},    32'(pass), 32'(expErr == 0));
    checkOutput({tag, "_busy"},    32'(busy), 0);
    checkOutput({tag, "_fv"},      32'(failValid), 32'(expValid));
    if (expValid != 0) begin
      checkOutput({tag, "_fa"}, 32'(failA), 32'(expA));
      checkOutput({tag, "_fb"}, 32'(failB), 32'(expB));
      checkOutput({tag, "_fp"}, 32'(failP), 32'(expP));
    end
    checkOutput({tag, "_lastA"}, 32'(multA), 32'((1 << WIDTH) - 1));
    checkOutput({tag, "_lastB"}, 32'(multB), 32'((1 << WIDTH) - 1));
    // Results must hold while idling in DONE.
    repeat (3) @(posedge clock);
    #1;
    checkOutput({tag, "_doneHeld"}, 32'(done), 1);
    checkOutput({tag, "_errHeld"},  32'(errCount), 32'(expErr));
  endtask

  initial begin
    int abortEdge, expPartial;
    checkCount = 0;
    errorCount = 0;
    candMode   = 0;
    start      = 1'b0;
    abort      = 1'b0;
    reset      = 1'b1;
    for (int i = 0; i < NVEC; i++) lut[i] = IW'(i);

    #12;
    checkAllZero("reset");
    @(negedge clock) reset = 1'b0;

    // Directed candidates: exact, stuck-at-zero, LSB inverted.
    applyStimulus("exact", 0, 1'b0);
    applyStimulus("stuck0", 1, 1'b0);
    applyStimulus("invLsb", 2, 1'b1);

    // Abort ten cycles into a run with an always-wrong candidate.
    candMode = 2;
    pulseStart();
    repeat (10) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    abortEdge  = 11;
    expPartial = 0;
    for (int k = 0; k < NVEC; k++)
      if (1 + (k + 1) * (SETTLE + 1) < abortEdge) expPartial++;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_pass", 32'(pass), 0);
    checkOutput("abort_err",  32'(errCount), 32'(expPartial));
    checkOutput("abort_fv",   32'(failValid), 1);
    repeat (4) @(posedge clock);
    #1 checkOutput("abort_stayIdle", 32'(busy), 0);
    applyStimulus("afterAbort", 0, 1'b0);

    // Simultaneous start and abort while in DONE: abort wins.
    #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clock); #1 begin start = 1'b0; abort = 1'b0; end
    checkOutput("startAbort_done", 32'(done), 0);
    checkOutput("startAbort_busy", 32'(busy), 0);

    // Asynchronous reset between edges in the middle of a sweep.
    candMode = 1;
    pulseStart();
    repeat (13) @(posedge clock);
    #3 reset = 1'b1;
    #1 checkAllZero("asyncRst");
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1 checkAllZero("postRst");

    // Randomised lookup-table candidates.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NVEC; i++) begin
        int prod;
        prod = (i / (1 << WIDTH)) * (i % (1 << WIDTH));
        lut[i] = IW'(prod);
        if ($urandom_range(0, 3) == 0) lut[i] = IW'($urandom);
      end
      applyStimulus($sformatf("rand%0d", r), 3, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Absolute time guard in case the DUT or bench stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
